// File: rtl/riscv_imm_decode_stage.sv
// -----------------------------------------------------------------------------
// riscv_imm_decode_stage
//
// Registered decode-stage slice for RV32I/RV64I. For each accepted instruction
// it generates the sign-extended immediate, classifies the immediate format,
// pre-computes the PC-relative target (pc + imm) and flags encodings that this
// stage does not recognise. Illegal entries still flow downstream, carrying a
// zero immediate, format NONE and target == pc.
//
// A two-entry buffer (main + skid) sits behind valid/ready handshakes on both
// sides. This gives full throughput while keeping in_ready a register output.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   flush          synchronous flush: drops buffered entries and any input
//                  presented in the same cycle
//   in_valid/in_ready, in_instr, in_pc             upstream handshake + payload
//   out_valid/out_ready                            downstream handshake
//   out_instr, out_pc                              passthrough payload
//   out_imm, out_imm_type, out_target, out_illegal decode results
//
// Immediate type codes: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
// -----------------------------------------------------------------------------
module riscv_imm_decode_stage #(
    parameter int INST_DATA_WIDTH = 32,
    parameter int XLEN            = 32,
    parameter int PC_WIDTH        = XLEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_DATA_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INST_DATA_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [XLEN-1:0]            out_imm,
    output logic [2:0]                 out_imm_type,
    output logic [PC_WIDTH-1:0]        out_target,
    output logic                       out_illegal
);

    // Immediate format codes
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OPC_LOAD       = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM   = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM     = 5'b00100;
    localparam logic [4:0] OPC_AUIPC      = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32  = 5'b00110;
    localparam logic [4:0] OPC_STORE      = 5'b01000;
    localparam logic [4:0] OPC_OP         = 5'b01100;
    localparam logic [4:0] OPC_LUI        = 5'b01101;
    localparam logic [4:0] OPC_OP_32      = 5'b01110;
    localparam logic [4:0] OPC_BRANCH     = 5'b11000;
    localparam logic [4:0] OPC_JALR       = 5'b11001;
    localparam logic [4:0] OPC_JAL        = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM     = 5'b11100;

    // Buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // One buffered, fully decoded entry
    typedef struct packed {
        logic [INST_DATA_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]        pc;
        logic [XLEN-1:0]            imm;
        logic [2:0]                 imm_type;
        logic [PC_WIDTH-1:0]        target;
        logic                       illegal;
    } entry_t;

    // Decode one instruction into a complete entry. Every format places
    // instr[31] at bit 31 of the 32-bit immediate, so one signed widening
    // to XLEN covers all sign extension, including U-type on RV64.
    function automatic entry_t decode_entry(
        input logic [INST_DATA_WIDTH-1:0] instr,
        input logic [PC_WIDTH-1:0]        pc
    );
        entry_t     e;
        logic [31:0] imm32;
        logic [2:0]  ty;
        logic        ill;
        imm32 = 32'd0;
        ty    = IMM_NONE;
        ill   = 1'b0;
        if (instr[1:0] != 2'b11) begin
            // Compressed or otherwise non-32-bit encoding
            ill = 1'b1;
        end else begin
            case (instr[6:2])
                OPC_LUI, OPC_AUIPC: begin
                    ty    = IMM_U;
                    imm32 = {instr[31:12], 12'h000};
                end
                OPC_JAL: begin
                    ty    = IMM_J;
                    imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
                end
                OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
                    ty    = IMM_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
                OPC_STORE: begin
                    ty    = IMM_S;
                    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                OPC_BRANCH: begin
                    ty    = IMM_B;
                    imm32 = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
                end
                OPC_OP, OPC_MISC_MEM: begin
                    ty    = IMM_NONE;
                    imm32 = 32'd0;
                end
                OPC_OP_IMM_32: begin
                    // Word-sized immediate ops only exist on RV64
                    if (XLEN == 64) begin
                        ty    = IMM_I;
                        imm32 = {{20{instr[31]}}, instr[31:20]};
                    end else begin
                        ill = 1'b1;
                    end
                end
                OPC_OP_32: begin
                    if (XLEN == 64) begin
                        ty = IMM_NONE;
                    end else begin
                        ill = 1'b1;
                    end
                end
                default: begin
                    ill = 1'b1;
                end
            endcase
        end
        e.instr    = instr;
        e.pc       = pc;
        e.imm      = XLEN'($signed(imm32));
        e.imm_type = ty;
        // Illegal entries carry imm == 0, so target collapses to pc
        e.target   = pc + PC_WIDTH'($signed(e.imm));
        e.illegal  = ill;
        return e;
    endfunction

    // Occupancy after this edge; flush empties the buffer regardless
    function automatic state_t next_count(
        input state_t cur,
        input logic   accept,
        input logic   drain,
        input logic   flush_req
    );
        state_t nxt;
        nxt = cur;
        if (flush_req) begin
            nxt = ST_EMPTY;
        end else begin
            case (cur)
                ST_EMPTY: nxt = accept ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
                    if (accept && !drain) begin
                        nxt = ST_TWO;
                    end else if (!accept && drain) begin
                        nxt = ST_EMPTY;
                    end else begin
                        nxt = ST_ONE;
                    end
                end
                ST_TWO:   nxt = drain ? ST_ONE : ST_TWO;
                default:  nxt = ST_EMPTY;
            endcase
        end
        return nxt;
    endfunction

    state_t state_r;
    state_t next_state_s;
    entry_t main_r;
    entry_t skid_r;
    entry_t dec_s;
    logic   in_ready_r;
    logic   out_valid_r;
    logic   accept_s;
    logic   drain_s;

    assign accept_s     = in_valid && in_ready_r;
    assign drain_s      = out_valid_r && out_ready;
    assign dec_s        = decode_entry(in_instr, in_pc);
    assign next_state_s = next_count(state_r, accept_s, drain_s, flush);

    // Occupancy FSM, handshake flags and entry storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            main_r      <= '0;
            skid_r      <= '0;
        end else if (flush) begin
            // Any input this cycle is dropped; a coinciding drain is final
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s != ST_TWO);
            out_valid_r <= (next_state_s != ST_EMPTY);
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_r <= dec_s;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        // Main drains and is reloaded in the same edge
                        main_r <= dec_s;
                    end else if (accept_s) begin
                        // Main is stalled; park the newcomer behind it
                        skid_r <= dec_s;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen
                    if (drain_s) begin
                        main_r <= skid_r;
                    end
                end
                default: begin
                    main_r <= '0;
                    skid_r <= '0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_instr    = main_r.instr;
    assign out_pc       = main_r.pc;
    assign out_imm      = main_r.imm;
    assign out_imm_type = main_r.imm_type;
    assign out_target   = main_r.target;
    assign out_illegal  = main_r.illegal;

endmodule

// File: tb/tb_riscv_imm_decode_stage.sv
// -----------------------------------------------------------------------------
// Bench for riscv_imm_decode_stage. A table of instructions with hand-derived
// expected immediates/targets feeds a scoreboard queue on every accept; each
// downstream transfer pops and compares. A second instance with XLEN = 64
// covers RV64-only decode and U-type sign extension.
// -----------------------------------------------------------------------------
module tb_riscv_imm_decode_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  ty;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    localparam int NV = 16;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_imm_type;
    logic [31:0] out_target;
    logic        out_illegal;

    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] in_instr64;
    logic [63:0] in_pc64;
    logic        out_valid64;
    logic        out_ready64;
    logic [31:0] out_instr64;
    logic [63:0] out_pc64;
    logic [63:0] out_imm64;
    logic [2:0]  out_imm_type64;
    logic [63:0] out_target64;
    logic        out_illegal64;

    int   check_cnt;
    int   error_cnt;
    int   pop_cnt;
    vec_t tbl [NV];
    vec_t cur;
    vec_t sb_q [$];

    riscv_imm_decode_stage #(.INST_DATA_WIDTH(32), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm),
        .out_imm_type(out_imm_type), .out_target(out_target),
        .out_illegal(out_illegal)
    );

    riscv_imm_decode_stage #(.INST_DATA_WIDTH(32), .XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .in_instr(in_instr64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .out_instr(out_instr64), .out_pc(out_pc64), .out_imm(out_imm64),
        .out_imm_type(out_imm_type64), .out_target(out_target64),
        .out_illegal(out_illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] im, input logic [2:0] t,
                                input logic [31:0] tg, input logic il);
        vec_t v;
        v.instr = i; v.pc = p; v.imm = im; v.ty = t; v.tgt = tg; v.ill = il;
        return v;
    endfunction

    task automatic drive(input int idx);
        in_valid = 1'b1;
        in_instr = tbl[idx].instr;
        in_pc    = tbl[idx].pc;
        cur      = tbl[idx];
    endtask

    // One clock: score the transfers about to happen, then advance to the
    // following falling edge where outputs are sampled.
    task automatic tick(output bit acc);
        bit   drn;
        vec_t e;
        acc = in_valid && in_ready && rst_n && !flush;
        drn = out_valid && out_ready && rst_n;
        if (drn) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'(out_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                pop_cnt++;
                check("sb_instr",   64'(out_instr),    64'(e.instr));
                check("sb_pc",      64'(out_pc),       64'(e.pc));
                check("sb_imm",     64'(out_imm),      64'(e.imm));
                check("sb_type",    64'(out_imm_type), 64'(e.ty));
                check("sb_target",  64'(out_target),   64'(e.tgt));
                check("sb_illegal", 64'(out_illegal),  64'(e.ill));
            end
        end
        if (!rst_n || flush) sb_q.delete();
        if (acc) sb_q.push_back(cur);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  64'(out_valid),    64'd0);
        check({tag, "_ready"},  64'(in_ready),     64'd0);
        check({tag, "_instr"},  64'(out_instr),    64'd0);
        check({tag, "_pc"},     64'(out_pc),       64'd0);
        check({tag, "_imm"},    64'(out_imm),      64'd0);
        check({tag, "_type"},   64'(out_imm_type), 64'd0);
        check({tag, "_target"}, 64'(out_target),   64'd0);
        check({tag, "_ill"},    64'(out_illegal),  64'd0);
    endtask

    initial begin
        bit acc;
        int idx;
        int cyc;
        int stalls;
        int pops0;

        check_cnt = 0; error_cnt = 0; pop_cnt = 0;
        tbl[0]  = mk(32'hFFF00093, 32'h000, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, 1'b0);
        tbl[1]  = mk(32'h0040006F, 32'h100, 32'h00000004, 3'd5, 32'h00000104, 1'b0);
        tbl[2]  = mk(32'hFE000EE3, 32'h200, 32'hFFFFFFFC, 3'd3, 32'h000001FC, 1'b0);
        tbl[3]  = mk(32'h00000000, 32'h300, 32'h00000000, 3'd0, 32'h00000300, 1'b1);
        tbl[4]  = mk(32'h0000007F, 32'h304, 32'h00000000, 3'd0, 32'h00000304, 1'b1);
        tbl[5]  = mk(32'h00112423, 32'h400, 32'h00000008, 3'd2, 32'h00000408, 1'b0);
        tbl[6]  = mk(32'h12345037, 32'h010, 32'h12345000, 3'd4, 32'h12345010, 1'b0);
        tbl[7]  = mk(32'h80000017, 32'h020, 32'h80000000, 3'd4, 32'h80000020, 1'b0);
        tbl[8]  = mk(32'h002081B3, 32'h030, 32'h00000000, 3'd0, 32'h00000030, 1'b0);
        tbl[9]  = mk(32'h0FF0000F, 32'h040, 32'h00000000, 3'd0, 32'h00000040, 1'b0);
        tbl[10] = mk(32'h80000067, 32'h050, 32'hFFFFF800, 3'd1, 32'hFFFFF850, 1'b0);
        tbl[11] = mk(32'h7FF02083, 32'h060, 32'h000007FF, 3'd1, 32'h0000085F, 1'b0);
        tbl[12] = mk(32'h0010009B, 32'h070, 32'h00000000, 3'd0, 32'h00000070, 1'b1);
        tbl[13] = mk(32'hFFDFF06F, 32'h080, 32'hFFFFFFFC, 3'd5, 32'h0000007C, 1'b0);
        tbl[14] = mk(32'h00000073, 32'h090, 32'h00000000, 3'd1, 32'h00000090, 1'b0);
        tbl[15] = mk(32'h00004501, 32'h0A0, 32'h00000000, 3'd0, 32'h000000A0, 1'b1);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 32'd0; cur = '0;
        in_valid64 = 1'b0; in_instr64 = 32'd0; in_pc64 = 64'd0; out_ready64 = 1'b1;

        // Reset state
        tick(acc); tick(acc);
        check_all_zero("rst");
        rst_n = 1'b1;
        tick(acc);
        check("rst_rel_ready", 64'(in_ready), 64'd1);
        check("rst_rel_valid", 64'(out_valid), 64'd0);

        // Single ADDI: one-cycle latency
        drive(0);
        tick(acc);
        in_valid = 1'b0;
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick(acc);
        check("lat_empty", 64'(out_valid), 64'd0);

        // Back-to-back stream, downstream stalled for the first 3 cycles
        idx = 0; cyc = 0; stalls = 0; pops0 = pop_cnt;
        while ((idx < NV || sb_q.size() != 0) && cyc < 200) begin
            if (idx < NV) drive(idx);
            else in_valid = 1'b0;
            out_ready = (cyc >= 3);
            tick(acc);
            if (acc) idx++;
            if (!acc && in_valid && cyc >= 4) stalls++;
            if (cyc == 1) check("full_in_ready", 64'(in_ready), 64'd0);
            if (cyc == 2) check("hold_instr", 64'(out_instr), 64'(tbl[0].instr));
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_accepts", 64'(idx), 64'(NV));
        check("stream_pops", 64'(pop_cnt - pops0), 64'(NV));
        check("stream_stalls", 64'(stalls), 64'd0);
        check("stream_cycles", 64'(cyc), 64'(NV + 3));

        // Flush with two entries buffered and an input presented
        out_ready = 1'b0;
        drive(1); tick(acc);
        drive(2); tick(acc);
        check("pre_flush_ready", 64'(in_ready), 64'd0);
        drive(3); flush = 1'b1;
        tick(acc);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        // Flush in ONE with an acceptable input and a coinciding drain
        drive(4); tick(acc);
        pops0 = pop_cnt;
        drive(5); flush = 1'b1; out_ready = 1'b1;
        tick(acc);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_drain_taken", 64'(pop_cnt - pops0), 64'd1);
        check("flush1_valid", 64'(out_valid), 64'd0);
        repeat (4) tick(acc);
        check("post_flush_quiet", 64'(pop_cnt - pops0), 64'd1);

        // Reset while two entries are buffered
        out_ready = 1'b0;
        drive(6); tick(acc);
        drive(7); tick(acc);
        drive(8); rst_n = 1'b0;
        tick(acc);
        check_all_zero("midrst");
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(acc);
        check("midrst_rel_ready", 64'(in_ready), 64'd1);
        pops0 = pop_cnt;
        repeat (3) tick(acc);
        check("midrst_quiet", 64'(pop_cnt - pops0), 64'd0);

        // XLEN = 64 instance
        in_valid64 = 1'b1; in_instr64 = 32'h12345037; in_pc64 = 64'h1000;
        tick(acc);
        check("x64_lui_valid", 64'(out_valid64), 64'd1);
        check("x64_lui_imm", out_imm64, 64'h0000000012345000);
        check("x64_lui_target", out_target64, 64'h0000000012346000);
        in_instr64 = 32'h80000037; in_pc64 = 64'h0;
        tick(acc);
        check("x64_lui_neg_imm", out_imm64, 64'hFFFFFFFF80000000);
        check("x64_lui_neg_type", 64'(out_imm_type64), 64'd4);
        in_instr64 = 32'h0010009B; in_pc64 = 64'h8;
        tick(acc);
        check("x64_addiw_type", 64'(out_imm_type64), 64'd1);
        check("x64_addiw_imm", out_imm64, 64'd1);
        check("x64_addiw_ill", 64'(out_illegal64), 64'd0);
        check("x64_addiw_target", out_target64, 64'd9);
        in_instr64 = 32'h0020803B; in_pc64 = 64'h10;
        tick(acc);
        check("x64_addw_type", 64'(out_imm_type64), 64'd0);
        check("x64_addw_ill", 64'(out_illegal64), 64'd0);
        in_valid64 = 1'b0;
        tick(acc);
        check("x64_drained", 64'(out_valid64), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/riscv_imm_decode_stage.md
Name: riscv_imm_decode_stage

Overview:
Registered decode-stage slice that generates the immediate for an RV32I/RV64I instruction and classifies its format. It also pre-computes the PC-relative target and flags unsupported opcodes. It sits between the fetch queue and the main decoder, with valid/ready handshakes on both sides. A 2-entry skid buffer gives full throughput with a registered `in_ready`.

Parameters:
- `INST_DATA_WIDTH`, 32: instruction width; only 32 is supported.
- `XLEN`, 32: immediate/PC/target width; legal values are 32 or 64.
- `PC_WIDTH`, `XLEN`: width of the PC and target fields.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  stage can accept; registered.
- `in_instr`  in  `INST_DATA_WIDTH`  instruction word.
- `in_pc`  in  `PC_WIDTH`  instruction PC.
- `out_valid`  out  1  downstream entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_instr`  out  `INST_DATA_WIDTH`  passthrough instruction.
- `out_pc`  out  `PC_WIDTH`  passthrough PC.
- `out_imm`  out  `XLEN`  sign-extended immediate.
- `out_imm_type`  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- `out_target`  out  `PC_WIDTH`  `out_pc + out_imm`, wrapping modulo 2^`PC_WIDTH`.
- `out_illegal`  out  1  unsupported or non-32-bit encoding.

Behaviour:
- Reset (`rst_n` = 0 at an edge):
  - `out_valid`, `in_ready` and all data outputs are 0; state goes to EMPTY.
  - `in_ready` = 1 from the first cycle after `rst_n` returns high.
- Handshakes:
  - A transfer occurs on any edge where valid && ready.
  - Payload is held stable while `out_valid` && !`out_ready`.
  - `out_valid` never drops without a transfer, except on flush or reset.
- Latency: an instruction accepted at edge N appears on the outputs after edge N (1 cycle). Order is preserved.
- Decode is combinational on `in_instr`/`in_pc`; results are captured into the main or skid register at acceptance.
- Format by `instr[6:2]`:
  - U: 01101, 00101 → `{instr[31:12], 12'b0}`.
  - J: 11011 → `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - I: 11001, 00000, 00100, 11100 → `instr[31:20]`.
  - S: 01000 → `{instr[31:25], instr[11:7]}`.
  - B: 11000 → `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - NONE, legal, `out_imm` = 0: 01100 (OP), 00011 (MISC-MEM).
  - When `XLEN` = 64 only: 00110 → I; 01110 → NONE.
- All immediates are sign-extended from `instr[31]` to `XLEN`. When `XLEN` = 64, the U-type value is also sign-extended.
- Illegal: `instr[1:0]` != 2'b11, or any opcode not listed above.
  - Forces `out_illegal` = 1, `out_imm` = 0, type NONE, `out_target` = `out_pc`.
  - The entry still flows through normally.
- State machine (entry count):
  - EMPTY: accept → ONE.
  - ONE: accept && !drain → TWO (new entry into skid); accept && drain → ONE (main reloaded); drain only → EMPTY.
  - TWO: drain → ONE (skid moves to main).
  - `in_ready` is 0 only in TWO; it is registered and computed from next-state.
- Simultaneous accept and drain in ONE gives full throughput with no bubble.
- Flush:
  - Next state is EMPTY; `out_valid` = 0 and `in_ready` = 1 after the edge.
  - Any input presented in the flush cycle is dropped.
  - A downstream transfer coinciding with flush still counts as taken.
  - Reset has priority over flush.
- Reset mid-operation discards all entries with no partial output.

Test Plan:
- ADDI 0xFFF00093, pc 0x0 → `out_imm` 0xFFFFFFFF, type 1, `out_target` 0xFFFFFFFF, `out_illegal` 0, `out_valid` 1 cycle after accept.
- JAL 0x0040006F at pc 0x100 → imm 0x4, type 5, target 0x104. BEQ 0xFE000EE3 at pc 0x200 → imm 0xFFFFFFFC, type 3, target 0x1FC.
- LUI 0x12345037 with `XLEN` = 64 → imm 0x0000000012345000. LUI 0x80000037 → 0xFFFFFFFF80000000.
- Stream 8 back-to-back instructions with `out_ready` held 0 for 3 cycles:
  - `in_ready` falls after 2 accepts.
  - No loss or duplication; order preserved.
  - Full rate once `out_ready` = 1.
- Word 0x00000000 → `out_illegal` 1, imm 0, type 0. Word 0x0000007F → `out_illegal` 1.
- With 2 entries buffered, assert `flush` together with `in_valid` → next cycle `out_valid` 0, `in_ready` 1, flushed input never emitted. Then assert reset while TWO → all outputs 0.
